// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// N-way arbiter with registered grant outputs. MODE selects the policy:
// 0 = fixed priority, where the lowest requesting index wins;
// 1 = round robin, where the search starts at a rotating pointer.
// While other requesters are waiting, an owner keeps the grant for at most
// MAX_HOLD consecutive cycles. With no contenders it keeps the grant for as
// long as it requests.
//
// The outputs show the decision made on the previous rising edge
// (one-cycle latency). A new owner can take over on the same edge that the
// old owner is released, so no idle cycle appears between owners.
//
// Ports
//   clk        in   1    rising-edge clock
//   reset      in   1    asynchronous, active-low; clears all state at once
//   req        in   N    level-sensitive request vector (bit i = requester i)
//   gnt        out  N    registered one-hot grant, or all zeros
//   gnt_valid  out  1    registered, equal to |gnt
//   gnt_id     out  IDW  registered index of the set gnt bit; 0 when idle
//   fsm_state  out  1    observability: 0 = IDLE, 1 = OWNED
//   ptr        out  IDW  observability: round-robin search start
//   hcnt       out  8    observability: cycles the current owner has held
//
// Handshake: there is no back-pressure. gnt_valid qualifies gnt and gnt_id in
// the cycle they are presented. A requester owns the resource in exactly
// those cycles where its gnt bit is 1.
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N        = 4,
   parameter int MODE     = 1,
   parameter int MAX_HOLD = 4,
   parameter int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id,
   output logic           fsm_state,
   output logic [IDW-1:0] ptr,
   output logic [7:0]     hcnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   localparam logic [7:0]     HOLD_LAST = 8'(MAX_HOLD - 1);
   localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);
   localparam logic [N-1:0]   ONE_N     = N'(1);

   state_t         state;

   logic           owner_req;
   logic           others_req;
   logic           expire;
   logic           keep;
   logic [N-1:0]   cand;
   logic [N-1:0]   hi_mask;
   logic [N-1:0]   sel;
   logic [N-1:0]   win_bit;
   logic           win_found;
   logic [IDW-1:0] win_id;
   logic [IDW-1:0] next_ptr;

   assign fsm_state = state;

   // gnt is the one-hot form of the current owner, so it doubles as the
   // owner mask.
   assign owner_req  = |(req & gnt);
   assign others_req = |(req & ~gnt);

   // Hold expiry uses >= rather than ==. An uncontended owner can run hcnt
   // past MAX_HOLD-1. When a contender then appears, the owner must give up
   // the grant at once instead of holding until hcnt wraps.
   assign expire = (state == OWNED) && owner_req && others_req &&
                   (hcnt >= HOLD_LAST);
   assign keep   = (state == OWNED) && owner_req && !expire;

   // A forced-out owner is removed from the candidates. In round-robin mode
   // this has no effect, because the pointer already places the owner last.
   assign cand = expire ? (req & ~gnt) : req;

   // Winner selection. In round robin the candidates at or above ptr are
   // searched first. If there are none, the search wraps to the low indices.
   // In fixed priority hi_mask stays empty, so the plain lowest bit wins.
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < N; i++) begin
         hi_mask[i] = (MODE != 0) && (i >= int'(ptr));
      end

      sel       = (|(cand & hi_mask)) ? (cand & hi_mask) : cand;
      win_bit   = sel & (~sel + ONE_N);     // isolate the lowest set bit
      win_found = |cand;

      win_id = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (win_bit[i]) begin
            win_id = IDW'(i);
         end
      end

      next_ptr = (win_id == LAST_ID) ? '0 : (win_id + IDW'(1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         ptr       <= '0;
         hcnt      <= '0;
      end else begin
         if (keep) begin
            // The owner continues. The counter saturates so that a very long
            // uncontended hold cannot wrap back into a fresh tenure.
            if (hcnt != 8'hFF) begin
               hcnt <= hcnt + 8'd1;
            end
         end else if (win_found) begin
            // New grant, either from IDLE or as a hand-over on this edge.
            state     <= OWNED;
            gnt       <= win_bit;
            gnt_valid <= 1'b1;
            gnt_id    <= win_id;
            hcnt      <= 8'd0;
            ptr       <= next_ptr;
         end else begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            hcnt      <= 8'd0;
         end
      end
   end

endmodule
